serial_reduce_seq: RTL and testbench

//  Multi-cycle sequencer for a SLICE-wide OR/NOR/AND/NAND reduction tree.

---
 rtl/serial_reduce_seq_pkg.sv | 35 +++
 rtl/serial_reduce_seq_if.sv | 32 +++
 rtl/serial_reduce_slice.sv | 39 +++
 rtl/serial_reduce_seq.sv | 121 ++++++++++++
 tb/tb_serial_reduce_seq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/serial_reduce_seq_pkg.sv
// Shared types and helpers for the serial OR/NOR/AND/NAND reduction sequencer.
// Holds the op encodings, the FSM state encoding and the beat arithmetic.
package serial_reduce_seq_pkg;

  typedef enum logic [1:0] {
    OP_OR   = 2'b00,
    OP_NOR  = 2'b01,
    OP_AND  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int numBeats(input int way, input int slice);
    return (way + slice - 1) / slice;
  endfunction

  function automatic int beatCountWidth(input int way, input int slice);
    return $clog2(numBeats(way, slice) + 1);
  endfunction

  // AND/NAND accumulate toward 0; OR/NOR accumulate toward 1.
  function automatic logic isAndFamily(input op_e op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  function automatic logic isInverting(input op_e op);
    return (op == OP_NOR) || (op == OP_NAND);
  endfunction

endpackage

// File: rtl/serial_reduce_seq_if.sv
// Operand/result handshake bundle for serial_reduce_seq.
// The slave modport is the sequencer side; the master modport is the producer/consumer side.
interface serial_reduce_seq_if
  import serial_reduce_seq_pkg::*;
#(
  parameter int WAY   = 16,
  parameter int SLICE = 4
);

  localparam int CW = beatCountWidth(WAY, SLICE);

  logic           in_valid;
  logic           in_ready;
  logic [WAY-1:0] in_data;
  logic [1:0]     in_op;
  logic           out_valid;
  logic           out_ready;
  logic           out_data;
  logic [CW-1:0]  out_beats;
  logic           busy;

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_data, out_beats, busy
  );

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_beats, busy
  );

endinterface

// File: rtl/serial_reduce_slice.sv
// Combinational N-input OR tree, split recursively into ceil/floor halves.
// BEHAVIORAL=0 builds each node as an inverted NOR; BEHAVIORAL=1 uses a plain reduction.
module serial_reduce_slice #(
  parameter int N          = 4,
  parameter int BEHAVIORAL = 0
) (
  input  logic [N-1:0] bits_i,
  output logic         or_o
);

  generate
    if (BEHAVIORAL != 0) begin : gBehav
      assign or_o = |bits_i;
    end else if (N == 1) begin : gLeaf
      assign or_o = bits_i[0];
    end else begin : gSplit
      localparam int N1 = (N + 1) / 2;
      localparam int N2 = N / 2;

      logic loOr;
      logic hiOr;
      logic norOut;

      serial_reduce_slice #(.N(N1), .BEHAVIORAL(BEHAVIORAL)) uLo (
        .bits_i (bits_i[N1-1:0]),
        .or_o   (loOr)
      );

      serial_reduce_slice #(.N(N2), .BEHAVIORAL(BEHAVIORAL)) uHi (
        .bits_i (bits_i[N-1:N1]),
        .or_o   (hiOr)
      );

      assign norOut = ~(loOr | hiOr);
      assign or_o   = ~norOut;
    end
  endgenerate

endmodule

// File: rtl/serial_reduce_seq.sv
// Multi-cycle OR/NOR/AND/NAND reduction: a WAY-bit operand is fed SLICE bits per cycle, LSB first.
// Optional SERIAL_REDUCE_EARLY_EXIT_EN stops as soon as the accumulator hits its dominant value.
module serial_reduce_seq
  import serial_reduce_seq_pkg::*;
#(
  parameter int WAY        = 16,
  parameter int SLICE      = 4,
  parameter int BEHAVIORAL = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_reduce_seq_if.slave   bus
);

  localparam int NB = numBeats(WAY, SLICE);
  localparam int CW = beatCountWidth(WAY, SLICE);
  localparam int PW = NB * SLICE;

  generate
    if (SLICE < 1 || SLICE > WAY) begin : gBadSlice
      $error("serial_reduce_seq: SLICE must satisfy 1 <= SLICE <= WAY");
    end
  endgenerate

  state_e          state_q;
  logic [PW-1:0]   data_q;
  op_e             op_q;
  logic            acc_q;
  logic [CW-1:0]   beat_q;
  logic            outValid_q;
  logic            outData_q;
  logic [CW-1:0]   outBeats_q;
  logic            busy_q;

  logic [PW-1:0]   paddedData;
  logic [SLICE-1:0] treeIn;
  logic            treeOr;
  logic            acc_d;
  logic            andFamily;
  logic            lastBeat;
  logic            finishRun;

  // Pad the top slice with the op's neutral element so it never disturbs the result.
  always_comb begin
    paddedData             = {PW{bus.in_op[1]}};
    paddedData[WAY-1:0]    = bus.in_data;
  end

  // The AND family goes through the OR tree as NOT(OR(~bits)).
  always_comb begin
    andFamily = isAndFamily(op_q);
    treeIn    = andFamily ? ~data_q[SLICE-1:0] : data_q[SLICE-1:0];
    acc_d     = andFamily ? (acc_q & ~treeOr) : (acc_q | treeOr);
    lastBeat  = (beat_q == CW'(NB - 1));
`ifdef SERIAL_REDUCE_EARLY_EXIT_EN
    finishRun = lastBeat || (acc_d == ~andFamily);
`else
    finishRun = lastBeat;
`endif
  end

  serial_reduce_slice #(.N(SLICE), .BEHAVIORAL(BEHAVIORAL)) uTree (
    .bits_i (treeIn),
    .or_o   (treeOr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      op_q       <= OP_OR;
      acc_q      <= 1'b0;
      beat_q     <= '0;
      outValid_q <= 1'b0;
      outData_q  <= 1'b0;
      outBeats_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q  <= paddedData;
            op_q    <= op_e'(bus.in_op);
            acc_q   <= bus.in_op[1];
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q  <= acc_d;
          data_q <= data_q >> SLICE;
          beat_q <= beat_q + CW'(1);
          if (finishRun) begin
            outValid_q <= 1'b1;
            outData_q  <= acc_d ^ isInverting(op_q);
            outBeats_q <= beat_q + CW'(1);
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_beats = outBeats_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_reduce_seq.sv
// Directed bench for serial_reduce_seq: a 16/4 instance and a 10/4 instance with padded last slice.
// Expected beat counts follow SERIAL_REDUCE_EARLY_EXIT_EN when it is defined for the build.
module tb_serial_reduce_seq;

`ifdef SERIAL_REDUCE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        tbValid;
  logic [15:0] tbData;
  logic [1:0]  tbOp;
  logic        tbOutReady;

  logic        obsInReady;
  logic        obsValid;
  logic        obsData;
  logic [2:0]  obsBeats;
  logic        obsBusy;

  int testsRun;
  int testsFailed;

  serial_reduce_seq_if #(.WAY(16), .SLICE(4)) if16 ();
  serial_reduce_seq_if #(.WAY(10), .SLICE(4)) if10 ();

  serial_reduce_seq #(.WAY(16), .SLICE(4), .BEHAVIORAL(0)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  serial_reduce_seq #(.WAY(10), .SLICE(4), .BEHAVIORAL(1)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if10)
  );

  assign if16.in_valid  = tbValid & ~sel;
  assign if16.in_data   = tbData;
  assign if16.in_op     = tbOp;
  assign if16.out_ready = tbOutReady & ~sel;
  assign if10.in_valid  = tbValid & sel;
  assign if10.in_data   = tbData[9:0];
  assign if10.in_op     = tbOp;
  assign if10.out_ready = tbOutReady & sel;

  assign obsInReady = sel ? if10.in_ready  : if16.in_ready;
  assign obsValid   = sel ? if10.out_valid : if16.out_valid;
  assign obsData    = sel ? if10.out_data  : if16.out_data;
  assign obsBeats   = sel ? {1'b0, if10.out_beats} : if16.out_beats;
  assign obsBusy    = sel ? if10.busy      : if16.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit useTen, input logic [1:0] op, input logic [15:0] data,
                               input logic expData, input int expBeats, input int stallCycles,
                               input bit pulseDuringRun, input string tag);
    int latency;
    sel = useTen;
    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, obsInReady, 1);
    tbValid = 1'b1;
    tbData  = data;
    tbOp    = op;
    @(posedge clk);
    #1;
    tbValid = 1'b0;
    latency = 0;
    do begin
      if (pulseDuringRun) begin
        tbValid = 1'b1;
        tbData  = ~data;
        tbOp    = ~op;
      end
      @(posedge clk);
      latency++;
      #1;
      tbValid = 1'b0;
      tbData  = data;
      tbOp    = op;
      if (pulseDuringRun && latency == 1)
        checkOutput({tag, " in_ready run"}, obsInReady, 0);
    end while (!obsValid && latency < 40);
    checkOutput({tag, " latency"}, latency, expBeats);
    checkOutput({tag, " out_data"}, obsData, expData);
    checkOutput({tag, " out_beats"}, obsBeats, expBeats);
    checkOutput({tag, " busy done"}, obsBusy, 1);
    checkOutput({tag, " in_ready done"}, obsInReady, 0);
    for (int i = 0; i < stallCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " stall out_valid"}, obsValid, 1);
      checkOutput({tag, " stall out_data"}, obsData, expData);
      checkOutput({tag, " stall out_beats"}, obsBeats, expBeats);
      checkOutput({tag, " stall in_ready"}, obsInReady, 0);
    end
    tbOutReady = 1'b1;
    @(posedge clk);
    #1;
    tbOutReady = 1'b0;
    checkOutput({tag, " out_valid after"}, obsValid, 0);
    checkOutput({tag, " busy after"}, obsBusy, 0);
    checkOutput({tag, " in_ready after"}, obsInReady, 1);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    sel         = 1'b0;
    tbValid     = 1'b0;
    tbData      = '0;
    tbOp        = 2'b00;
    tbOutReady  = 1'b0;

    #12;
    checkOutput("reset out_valid", if16.out_valid, 0);
    checkOutput("reset out_data", if16.out_data, 0);
    checkOutput("reset out_beats", if16.out_beats, 0);
    checkOutput("reset busy", if16.busy, 0);
    checkOutput("reset busy w10", if10.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", if16.in_ready, 1);

    applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0, 4,             0, 1'b0, "OR 0000");
    applyStimulus(1'b0, 2'b01, 16'h0100, 1'b0, EE ? 3 : 4,    0, 1'b0, "NOR 0100");
    applyStimulus(1'b0, 2'b10, 16'hFFFF, 1'b1, 4,             0, 1'b0, "AND FFFF");
    applyStimulus(1'b0, 2'b11, 16'hFFFE, 1'b1, EE ? 1 : 4,    0, 1'b0, "NAND FFFE");
    applyStimulus(1'b0, 2'b00, 16'h0010, 1'b1, EE ? 2 : 4,    5, 1'b1, "OR 0010 stall");
    applyStimulus(1'b0, 2'b01, 16'h0000, 1'b1, 4,             0, 1'b0, "NOR 0000");
    applyStimulus(1'b0, 2'b11, 16'hFFFF, 1'b0, 4,             0, 1'b0, "NAND FFFF");

    applyStimulus(1'b1, 2'b10, 16'h03FF, 1'b1, 3,             0, 1'b0, "W10 AND 3FF");
    applyStimulus(1'b1, 2'b00, 16'h0200, 1'b1, 3,             0, 1'b0, "W10 OR 200");
    applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0, 3,             0, 1'b0, "W10 OR 000");
    applyStimulus(1'b1, 2'b11, 16'h03FF, 1'b0, 3,             0, 1'b0, "W10 NAND 3FF");

    // Abort an operation mid-run with an asynchronous reset between clock edges.
    sel = 1'b0;
    @(negedge clk);
    tbValid = 1'b1;
    tbData  = 16'h0000;
    tbOp    = 2'b00;
    @(posedge clk);
    #1;
    tbValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("abort busy before", if16.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", if16.out_valid, 0);
    checkOutput("abort busy", if16.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 2'b00, 16'h8000, 1'b1, 4,             0, 1'b0, "OR 8000 post-abort");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
